// File: rtl/etc_th_block_decoder_if.sv
// Block-descriptor in / RGBA-beat out bundle for the ETC2 T/H block decoder.
// master = descriptor producer and beat consumer, slave = decoder.
interface etc_th_block_decoder_if #(
  parameter int unsigned PIX_PER_CYCLE = 1
);
  localparam int unsigned RGBA_W = 32 * PIX_PER_CYCLE;

  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_block;
  logic [23:0]       in_color0;
  logic [23:0]       in_color1;
  logic [23:0]       in_color2;
  logic [23:0]       in_color3;
  logic              in_punch;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_pix_idx;
  logic [RGBA_W-1:0] out_rgba;
  logic              out_last;

  modport master (
    output in_valid, in_block, in_color0, in_color1, in_color2, in_color3,
           in_punch, out_ready,
    input  in_ready, out_valid, out_pix_idx, out_rgba, out_last
  );

  modport slave (
    input  in_valid, in_block, in_color0, in_color1, in_color2, in_color3,
           in_punch, out_ready,
    output in_ready, out_valid, out_pix_idx, out_rgba, out_last
  );
endinterface

// File: rtl/etc_th_block_decoder.sv
// ETC2 T/H-mode block decoder: expands one descriptor into 16 RGBA pixels,
// PIX_PER_CYCLE per beat. Define ETC_TH_PUNCHTHROUGH_EN for punch-through alpha.
module etc_th_block_decoder #(
  parameter int unsigned PIX_PER_CYCLE = 1
) (
  input logic                    sclk,
  input logic                    rsrt,
  etc_th_block_decoder_if.slave  io
);

  localparam int unsigned BEATS     = 16 / PIX_PER_CYCLE;
  localparam int unsigned RGBA_W    = 32 * PIX_PER_CYCLE;
  localparam logic [3:0]  LAST_BEAT = 4'(BEATS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            beat_q, beat_d;
  logic [31:0]           blk_q, blk_d;
  logic [3:0][23:0]      col_q, col_d;
  logic                  rdy_en_q, rdy_en_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [3:0]            pix_idx_q, pix_idx_d;
  logic [RGBA_W-1:0]     rgba_q, rgba_d;
`ifdef ETC_TH_PUNCHTHROUGH_EN
  logic                  punch_q, punch_d;
  logic                  src_punch;
`endif

  logic                  fire;
  logic                  in_ready_c;
  logic                  accept;
  logic                  load;
  logic                  adv;
  logic [31:0]           src_blk;
  logic [3:0][23:0]      src_col;
  logic [3:0]            nxt_beat;
  logic [RGBA_W-1:0]     nxt_rgba;

  // Upper half of the block word (T/H colour fields) is decoded upstream.
  logic unused_in;
`ifdef ETC_TH_PUNCHTHROUGH_EN
  assign unused_in = ^io.in_block[63:32];
`else
  assign unused_in = ^{io.in_block[63:32], io.in_punch};
`endif

  // Handshake terms; in_ready opens in the same cycle the last beat is taken.
  always_comb begin
    fire       = out_valid_q & io.out_ready;
    in_ready_c = rdy_en_q & ((state_q == ST_IDLE) | (fire & out_last_q));
    accept     = io.in_valid & in_ready_c;
  end

  // Next beat's pixels, from the incoming descriptor on accept, else from the captured one.
  always_comb begin
    logic [3:0]  p;
    logic [1:0]  sel;
    logic [31:0] lane;
    p        = '0;
    sel      = '0;
    lane     = '0;
    nxt_rgba = '0;
    src_blk  = accept ? io.in_block[31:0] : blk_q;
    src_col  = accept ? {io.in_color3, io.in_color2, io.in_color1, io.in_color0} : col_q;
`ifdef ETC_TH_PUNCHTHROUGH_EN
    src_punch = accept ? io.in_punch : punch_q;
`endif
    nxt_beat = accept ? 4'd0 : beat_q + 4'd1;
    for (int unsigned k = 0; k < PIX_PER_CYCLE; k++) begin
      p    = 4'((32'(nxt_beat) * PIX_PER_CYCLE) + k);
      sel  = {src_blk[{1'b1, p}], src_blk[{1'b0, p}]};
      lane = {8'hFF, src_col[sel]};
`ifdef ETC_TH_PUNCHTHROUGH_EN
      if (src_punch && (sel == 2'd2)) begin
        lane = 32'h0000_0000;
      end
`endif
      nxt_rgba[32*k +: 32] = lane;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    blk_d       = blk_q;
    col_d       = col_q;
    rdy_en_d    = 1'b1;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pix_idx_d   = pix_idx_q;
    rgba_d      = rgba_q;
`ifdef ETC_TH_PUNCHTHROUGH_EN
    punch_d     = punch_q;
`endif
    load        = 1'b0;
    adv         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EMIT;
          load    = 1'b1;
        end
      end
      ST_EMIT: begin
        if (fire) begin
          if (out_last_q) begin
            if (accept) begin
              load = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      blk_d   = io.in_block[31:0];
      col_d   = {io.in_color3, io.in_color2, io.in_color1, io.in_color0};
`ifdef ETC_TH_PUNCHTHROUGH_EN
      punch_d = io.in_punch;
`endif
    end

    if (load || adv) begin
      beat_d      = nxt_beat;
      out_valid_d = 1'b1;
      out_last_d  = (nxt_beat == LAST_BEAT);
      pix_idx_d   = 4'(32'(nxt_beat) * PIX_PER_CYCLE);
      rgba_d      = nxt_rgba;
    end
  end

  always_ff @(posedge sclk or negedge rsrt) begin
    if (!rsrt) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      blk_q       <= '0;
      col_q       <= '0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pix_idx_q   <= '0;
      rgba_q      <= '0;
`ifdef ETC_TH_PUNCHTHROUGH_EN
      punch_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      blk_q       <= blk_d;
      col_q       <= col_d;
      rdy_en_q    <= rdy_en_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pix_idx_q   <= pix_idx_d;
      rgba_q      <= rgba_d;
`ifdef ETC_TH_PUNCHTHROUGH_EN
      punch_q     <= punch_d;
`endif
    end
  end

  assign io.in_ready    = in_ready_c;
  assign io.out_valid   = out_valid_q;
  assign io.out_last    = out_last_q;
  assign io.out_pix_idx = pix_idx_q;
  assign io.out_rgba    = rgba_q;

endmodule

// File: doc/etc_th_block_decoder.md
ETC_TH_BLOCK_DECODER -- requirements
Module: etc_th_block_decoder

Interface
REQ-001 Parameter: PIX_PER_CYCLE, default 1, pixels emitted per output beat; legal values 1, 2, 4, 8, 16.
REQ-002 Port: sclk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: rsrt  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  in  1  input block descriptor valid.
REQ-005 Port: in_ready  out  1  block decoder can accept a descriptor.
REQ-006 Port: in_block  in  64  ETC2 T/H-mode block; only bits [31:0] (pixel index bits) are used.
REQ-007 Port: in_color0..in_color3  in  24 each  paint colours, R=[7:0], G=[15:8], B=[23:16].
REQ-008 Port: in_punch  in  1  punch-through flag for this block.
REQ-009 Port: out_valid  out  1  output beat valid.
REQ-010 Port: out_ready  in  1  downstream accepts beat.
REQ-011 Port: out_pix_idx  out  4  index of lane-0 pixel in current beat.
REQ-012 Port: out_rgba  out  32*PIX_PER_CYCLE  lane k at [32k+31:32k] = {A,B,G,R}, R in low byte.
REQ-013 Port: out_last  out  1  current beat carries pixel 15.

Function
REQ-014 FSM states IDLE and EMIT; in_ready = 1 in IDLE, or in EMIT when out_valid & out_ready & out_last; 0 otherwise.
REQ-015 Accept = in_valid & in_ready; on accept, in_block[31:0], in_color0..3 and in_punch are registered, beat counter cleared, state -> EMIT.
REQ-016 out_valid asserts the cycle after accept (latency 1) and stays high until the last beat is taken.
REQ-017 Beats per block = 16/PIX_PER_CYCLE; beat b, lane k carries pixel p = b*PIX_PER_CYCLE + k; out_pix_idx = b*PIX_PER_CYCLE.
REQ-018 Pixel p colour index = {blk[p+16], blk[p]}; lane RGB = in_colorN for that index; A = 8'hFF.
REQ-019 Beat advances only on out_valid & out_ready; while out_valid & !out_ready, out_rgba, out_pix_idx, out_last held stable.
REQ-020 out_last = 1 exactly when b = 16/PIX_PER_CYCLE - 1 (PIX_PER_CYCLE=16: every beat).
REQ-021 Last beat taken with no new accept -> IDLE, out_valid 0 next cycle.
REQ-022 Last beat taken with simultaneous accept -> stay EMIT, first beat of new block valid next cycle (no bubble).
REQ-023 in_valid while in_ready = 0 is ignored; captured registers unchanged.
REQ-024 Outputs registered; no combinational path from in_* to out_*; in_ready depends only on state, out_last, out_ready.

Reset
REQ-025 rsrt low asynchronously forces: state IDLE, beat counter 0, out_valid 0, out_last 0, out_pix_idx 0, out_rgba 0, captured registers 0.
REQ-026 in_ready = 0 while rsrt low; = 1 from first sclk edge after release.
REQ-027 Reset mid-block abandons the block; no further beats for it after release.

Configuration
REQ-028 Macro ETC_TH_PUNCHTHROUGH_EN defined: pixel with captured in_punch = 1 and index 2 outputs RGBA 32'h00000000; other pixels unchanged.
REQ-029 Macro undefined: in_punch ignored (no register), all pixels A = 8'hFF.

Verification
REQ-030 PIX_PER_CYCLE=1, block 64'hf387b98341197667, colours 24'h000010/20/30/40, out_ready=1 -> 16 consecutive beats; pixel 0..3 = 32'hFF000040, FF000020, FF000020, FF000030; out_last only on beat 15.
REQ-031 PIX_PER_CYCLE=4, same block -> 4 beats, out_pix_idx 0,4,8,12; beat 0 out_rgba = {FF000030,FF000020,FF000020,FF000040}.
REQ-032 Macro defined, same block, in_punch=1 -> pixel 3 = 32'h00000000, pixels 0..2 unchanged; macro undefined -> pixel 3 = 32'hFF000030.
REQ-033 out_ready toggling 1,0,0,1 during EMIT -> beat held across stalled cycles, no pixel skipped or repeated, 16 pixels total.
REQ-034 Second descriptor valid during last beat of first, out_ready=1 -> in_ready=1 that cycle, first beat of block 2 next cycle, no idle cycle.
REQ-035 rsrt low at beat 7 -> out_valid 0 immediately (asynchronous); after release in_ready=1, no residual beats.
